// File: rtl/ip_frame_to_nn_streamer.sv
// Captures a pixel frame plus sender metadata and streams it to a neural-net write port,
// LANES pixels per beat, row-major. Frames arriving while busy are dropped and counted.
module ip_frame_to_nn_streamer #(
  parameter int ROWS       = 28,
  parameter int COLS       = 28,
  parameter int PIX_BITS   = 8,
  parameter int DATA_W     = 18,
  parameter int FRAC_SHIFT = 2,
  parameter int LANES      = 1,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int FB = ROWS * COLS * PIX_BITS
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [0:FB-1]           DATA_FRAME_IP,
  input  logic [31:0]             SRC_IP_ADDRESS_IP,
  input  logic [47:0]             SRC_MAC_ADDRESS_IP,
  input  logic [15:0]             SRC_UDP_PORT_IP,
  input  logic                    FRAME_READY,
  input  logic                    W_READY,
  output logic [31:0]             SRC_IP_ADDRESS_NN,
  output logic [47:0]             SRC_MAC_ADDRESS_NN,
  output logic [15:0]             SRC_UDP_PORT_NN,
  output logic [LANES*DATA_W-1:0] W_DATA,
  output logic                    W_EN,
  output logic [RW-1:0]           W_ROW,
  output logic [CW-1:0]           W_COL,
  output logic                    W_DONE,
  output logic                    BUSY,
  output logic [15:0]             DROP_COUNT
);

  localparam int NPIX = ROWS * COLS;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  if (COLS % LANES != 0) begin : g_lanes_chk
    $error("COLS must be a multiple of LANES");
  end
  if (PIX_BITS + FRAC_SHIFT > DATA_W) begin : g_width_chk
    $error("PIX_BITS + FRAC_SHIFT must fit in DATA_W");
  end

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic                  accept;
  logic [PIX_BITS-1:0]   pix_q [NPIX];
  logic [31:0]           ip_q;
  logic [47:0]           mac_q;
  logic [15:0]           port_q;
  logic [15:0]           drop_q;
  logic [PW-1:0]         base;
  logic                  stream;
  logic                  row_end;
  logic                  last_beat;

  assign stream    = (state_q == StStream);
  assign row_end   = (col_q == CW'(COLS - LANES));
  assign last_beat = row_end && (row_q == RW'(ROWS - 1));
  assign base      = PW'(int'(row_q) * COLS + int'(col_q));

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      ip_q    <= '0;
      mac_q   <= '0;
      port_q  <= '0;
      drop_q  <= '0;
      for (int p = 0; p < NPIX; p++) pix_q[p] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      if (accept) begin
        ip_q   <= SRC_IP_ADDRESS_IP;
        mac_q  <= SRC_MAC_ADDRESS_IP;
        port_q <= SRC_UDP_PORT_IP;
        for (int p = 0; p < NPIX; p++) pix_q[p] <= DATA_FRAME_IP[p*PIX_BITS +: PIX_BITS];
      end
      // Any frame offered while not idle (including the DONE cycle) is rejected.
      if (FRAME_READY && (state_q != StIdle) && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (FRAME_READY) begin
          accept  = 1'b1;
          state_d = StStream;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StStream: begin
        if (W_READY) begin
          if (last_beat) begin
            state_d = StDone;
            row_d   = '0;
            col_d   = '0;
          end else if (row_end) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CW'(LANES);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        row_d   = '0;
        col_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    W_EN   = stream;
    W_DONE = (state_q == StDone);
    BUSY   = (state_q != StIdle);
    W_DATA = '0;
    W_ROW  = '0;
    W_COL  = '0;
    if (stream) begin
      W_ROW = row_q;
      W_COL = col_q;
      for (int k = 0; k < LANES; k++) begin
        W_DATA[k*DATA_W +: DATA_W] = DATA_W'(pix_q[base + PW'(k)]) << FRAC_SHIFT;
      end
    end
  end

  assign SRC_IP_ADDRESS_NN  = ip_q;
  assign SRC_MAC_ADDRESS_NN = mac_q;
  assign SRC_UDP_PORT_NN    = port_q;
  assign DROP_COUNT         = drop_q;

endmodule
